// File: rtl/decoder_scan_sequencer.sv
// decoder_scan_sequencer: handshaked dwell scan of a 4-bit decoder input.
// Optional SCAN_SKIP_MASK_EN adds skip_mask to drop codes from the scan.
module decoder_scan_sequencer #(
  parameter int DWELL  = 10,
  parameter int PASS_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              dir,
  input  logic              continuous,
`ifdef SCAN_SKIP_MASK_EN
  input  logic [15:0]       skip_mask,
`endif
  output logic [3:0]        code_out,
  output logic              code_valid,
  output logic              busy,
  output logic              done,
  output logic [PASS_W-1:0] pass_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [7:0] DWELL_M1 = 8'(DWELL - 1);

  state_t            state_q, state_d;
  logic [3:0]        code_q, code_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              dir_q, dir_d;
  logic [PASS_W-1:0] pass_q, pass_d;
  logic [15:0]       mask_q;
  logic [15:0]       start_mask;
  logic              all_masked;

`ifdef SCAN_SKIP_MASK_EN
  logic [15:0] mask_d;
  assign start_mask = skip_mask;
`else
  assign start_mask = '0;
  assign mask_q     = '0;
`endif

  assign all_masked = &start_mask;

  // First unmasked code seen from the start end of the scan.
  function automatic logic [3:0] first_c(
    input logic        d,
    input logic [15:0] m
  );
    first_c = d ? 4'hF : 4'h0;
    if (!d) begin
      for (int i = 15; i >= 0; i--)
        if (!m[i]) first_c = 4'(i);
    end else begin
      for (int i = 0; i < 16; i++)
        if (!m[i]) first_c = 4'(i);
    end
  endfunction

  // Last code of a pass is the first code seen from the far end.
  function automatic logic [3:0] last_c(
    input logic        d,
    input logic [15:0] m
  );
    last_c = first_c(~d, m);
  endfunction

  // Nearest unmasked code beyond c in the scan direction.
  function automatic logic [3:0] next_c(
    input logic [3:0]  c,
    input logic        d,
    input logic [15:0] m
  );
    next_c = c;
    if (!d) begin
      for (int i = 15; i >= 0; i--)
        if (4'(i) > c && !m[i]) next_c = 4'(i);
    end else begin
      for (int i = 0; i < 16; i++)
        if (4'(i) < c && !m[i]) next_c = 4'(i);
    end
  endfunction

  // Next-state logic: start/abort handshake, dwell stepping, pass wrap.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    pass_d  = pass_q;
`ifdef SCAN_SKIP_MASK_EN
    mask_d  = mask_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
`ifdef SCAN_SKIP_MASK_EN
          mask_d = start_mask;
`endif
          dir_d = dir;
          if (all_masked) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
            code_d  = first_c(dir, start_mask);
            cnt_d   = '0;
          end
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (cnt_q == DWELL_M1) begin
          cnt_d = '0;
          if (code_q == last_c(dir_q, mask_q)) begin
            if (pass_q != '1)
              pass_d = pass_q + 1'b1;
            if (continuous)
              code_d = first_c(dir_q, mask_q);
            else
              state_d = S_DONE;
          end else begin
            code_d = next_c(code_q, dir_q, mask_q);
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      code_q  <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      pass_q  <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      pass_q  <= pass_d;
    end
  end

`ifdef SCAN_SKIP_MASK_EN
  // Skip mask captured when a scan is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mask_q <= '0;
    else        mask_q <= mask_d;
  end
`endif

  assign code_out   = code_q;
  assign code_valid = (state_q == S_RUN);
  assign busy       = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);
  assign pass_count = pass_q;

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// tb_decoder_scan_sequencer: randomized self-checking bench.
// Exercises scans, abort, async reset and, with SCAN_SKIP_MASK_EN, masks.
module tb_decoder_scan_sequencer;

  localparam int DWELL  = 10;
  localparam int PASS_W = 8;
  localparam int PMAX   = (1 << PASS_W) - 1;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              abort;
  logic              dir;
  logic              continuous;
  logic [3:0]        code_out;
  logic              code_valid;
  logic              busy;
  logic              done;
  logic [PASS_W-1:0] pass_count;
`ifdef SCAN_SKIP_MASK_EN
  logic [15:0]       skip_mask;
`endif

  int pass_n;
  int total_n;
  int exp_pass;

  decoder_scan_sequencer #(
    .DWELL (DWELL),
    .PASS_W(PASS_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .dir       (dir),
    .continuous(continuous),
`ifdef SCAN_SKIP_MASK_EN
    .skip_mask (skip_mask),
`endif
    .code_out  (code_out),
    .code_valid(code_valid),
    .busy      (busy),
    .done      (done),
    .pass_count(pass_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int sat(input int v);
    return (v > PMAX) ? PMAX : v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full scan of `passes` passes against a sequence list built from the rules.
  task automatic scan(input bit d, input int passes, input logic [15:0] m);
    int seq[$];
    int n, len, p0, p;
    logic [6:0] got, want;
    for (int i = 0; i < 16; i++) begin
      int c;
      c = d ? 15 - i : i;
      if (!m[c]) seq.push_back(c);
    end
    n = seq.size();
    p0 = exp_pass;
    start = 1'b1;
    abort = 1'b0;
    dir = d;
    continuous = (passes > 1);
`ifdef SCAN_SKIP_MASK_EN
    skip_mask = m;
`endif
    step();
    start = 1'b0;
    dir = 1'($urandom);
    if (n == 0) begin
      total_n++;
      if ({done, code_valid, busy} !== 3'b100 || pass_count !== PASS_W'(exp_pass))
        $display("FAIL allmask_done got d/v/b=%b%b%b pc=%0d want 100 pc=%0d",
                 done, code_valid, busy, pass_count, exp_pass);
      else pass_n++;
      step();
      total_n++;
      if ({done, code_valid, busy} !== 3'b000)
        $display("FAIL allmask_idle got d/v/b=%b%b%b want 000",
                 done, code_valid, busy);
      else pass_n++;
      return;
    end
    len = n * DWELL;
    for (int t = 0; t < passes * len; t++) begin
      p = t / len;
      got = {code_out, code_valid, busy, done};
      want = {4'(seq[(t / DWELL) % n]), 3'b110};
      total_n++;
      if (got !== want || pass_count !== PASS_W'(sat(p0 + p)))
        $display("FAIL scan t=%0d got code/v/b/d=%h pc=%0d want %h pc=%0d",
                 t, got, pass_count, want, sat(p0 + p));
      else pass_n++;
      if (t % len == len - 1) continuous = (p < passes - 1);
      else continuous = 1'($urandom);
      start = 1'($urandom);
      dir = 1'($urandom);
      step();
    end
    exp_pass = sat(exp_pass + passes);
    start = 1'b0;
    total_n++;
    if ({done, code_valid, busy} !== 3'b100 || pass_count !== PASS_W'(exp_pass))
      $display("FAIL done_pulse got d/v/b=%b%b%b pc=%0d want 100 pc=%0d",
               done, code_valid, busy, pass_count, exp_pass);
    else pass_n++;
    step();
    total_n++;
    if ({done, code_valid, busy} !== 3'b000 || code_out !== 4'(seq[n - 1]))
      $display("FAIL post_done got d/v/b=%b%b%b code=%0d want 000 code=%0d",
               done, code_valid, busy, code_out, seq[n - 1]);
    else pass_n++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    dir = 1'b0;
    continuous = 1'b0;
`ifdef SCAN_SKIP_MASK_EN
    skip_mask = '0;
`endif
    exp_pass = 0;
    step();
    step();
    rst_n = 1'b1;
    step();
    total_n++;
    if ({code_out, code_valid, busy, done} !== 7'h00 || pass_count !== '0)
      $display("FAIL reset got code=%0d v/b/d=%b%b%b pc=%0d want all 0",
               code_out, code_valid, busy, done, pass_count);
    else pass_n++;
  endtask

  task automatic test_single_up();
    scan(1'b0, 1, 16'h0000);
  endtask

  task automatic test_single_down();
    scan(1'b1, 1, 16'h0000);
  endtask

  task automatic test_continuous();
    scan(1'b0, 4, 16'h0000);
  endtask

  // Abort mid-dwell at code 7, then on the final dwell cycle of a pass.
  task automatic test_abort();
    int stop_t [2];
    stop_t[0] = 7 * DWELL + 4;
    stop_t[1] = 16 * DWELL - 1;
    for (int k = 0; k < 2; k++) begin
      start = 1'b1;
      dir = 1'b0;
      continuous = 1'b0;
`ifdef SCAN_SKIP_MASK_EN
      skip_mask = '0;
`endif
      step();
      start = 1'b0;
      for (int t = 0; t <= stop_t[k]; t++) begin
        total_n++;
        if (code_out !== 4'(t / DWELL) || code_valid !== 1'b1)
          $display("FAIL abort_run t=%0d got code=%0d v=%b want %0d v=1",
                   t, code_out, code_valid, t / DWELL);
        else pass_n++;
        if (t == stop_t[k]) abort = 1'b1;
        step();
      end
      abort = 1'b0;
      total_n++;
      if ({code_valid, busy, done} !== 3'b000 || pass_count !== PASS_W'(exp_pass)
          || code_out !== 4'(stop_t[k] / DWELL))
        $display("FAIL abort k=%0d got v/b/d=%b%b%b pc=%0d code=%0d want 000 pc=%0d",
                 k, code_valid, busy, done, pass_count, code_out, exp_pass);
      else pass_n++;
      step();
      total_n++;
      if ({code_valid, busy, done} !== 3'b000)
        $display("FAIL abort_nodone got v/b/d=%b%b%b want 000",
                 code_valid, busy, done);
      else pass_n++;
    end
  endtask

  task automatic test_start_abort_idle();
    start = 1'b1;
    abort = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total_n++;
      if ({code_valid, busy, done} !== 3'b000)
        $display("FAIL start_abort_idle got v/b/d=%b%b%b want 000",
                 code_valid, busy, done);
      else pass_n++;
    end
    start = 1'b0;
    abort = 1'b0;
    scan(1'b0, 1, 16'h0000);
  endtask

`ifdef SCAN_SKIP_MASK_EN
  task automatic test_skip_mask();
    scan(1'b0, 1, 16'h00FF);
    scan(1'b1, 2, 16'($urandom));
    scan(1'b0, 1, 16'hFFFF);
    scan(1'b1, 2, 16'hFBFF);
  endtask
`endif

  // Async reset between edges, then saturation of pass_count.
  task automatic test_async_reset_sat();
    start = 1'b1;
    dir = 1'b0;
    continuous = 1'b1;
    step();
    start = 1'b0;
    repeat (37) step();
    #2;
    rst_n = 1'b0;
    #1;
    total_n++;
    if ({code_out, code_valid, busy, done} !== 7'h00 || pass_count !== '0)
      $display("FAIL async_reset got code=%0d v/b/d=%b%b%b pc=%0d want all 0",
               code_out, code_valid, busy, done, pass_count);
    else pass_n++;
    exp_pass = 0;
    continuous = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    scan(1'b0, PMAX + 2, 16'h0000);
  endtask

  initial begin
    pass_n = 0;
    total_n = 0;
    test_reset();
    test_single_up();
    test_single_down();
    test_continuous();
    test_abort();
    test_start_abort_idle();
`ifdef SCAN_SKIP_MASK_EN
    test_skip_mask();
`endif
    test_async_reset_sat();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule

// File: doc/decoder_scan_sequencer.md
Name: decoder_scan_sequencer

Overview:
Upstream driver for the 4-to-16 decoder. It steps a 4-bit code through all 16 values, holding each for a fixed number of clock cycles, and drives the decoder's 4-bit input. It replaces free-running stimulus with a controlled, handshaked scan: start, abort, direction select, optional looping, a done pulse and a pass counter.

Parameters:
DWELL, 10, clock cycles each code is held; legal range 1..255.
PASS_W, 8, width of pass_count.

Ports:
clk  input  1  clock; all flops rise-edge triggered.
rst_n  input  1  asynchronous active-low reset.
start  input  1  single-cycle request to begin a scan; honoured only in IDLE.
abort  input  1  terminates a scan in progress; no done pulse.
dir  input  1  0 = up (0→15), 1 = down (15→0); sampled only when start is accepted.
continuous  input  1  1 = wrap and rescan after the last code; sampled at each end-of-pass decision.
code_out  output  4  code presented to decoder input.
code_valid  output  1  high while code_out is a live scan code.
busy  output  1  high in RUN.
done  output  1  one-cycle pulse after a non-continuous pass completes.
pass_count  output  PASS_W  number of completed full passes; saturating.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, code_out=4'h0, code_valid=0, busy=0, done=0, pass_count=0, dwell counter=0, latched dir=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 and abort=0 → RUN at the next edge.
  - On entry, code_out is the first code (0 if dir=0, 15 if dir=1), code_valid=1, busy=1, dwell counter=0.
  - code_out holds its last value while in IDLE.
  - start and abort both high in IDLE → stay IDLE (abort wins).
- RUN:
  - The dwell counter increments every cycle.
  - At counter==DWELL-1 with code_out not the last code (15 up, 0 down): code_out steps ±1 and the counter clears.
  - At counter==DWELL-1 with code_out the last code:
    - pass_count increments (saturates at all-ones).
    - If continuous=1: code_out wraps to the first code, the counter clears, and the FSM stays in RUN.
    - If continuous=0: DONE at the next edge.
  - Each code is therefore valid for exactly DWELL cycles. One pass is 16*DWELL cycles with code_valid high.
  - DWELL=1 steps the code every cycle.
- Start latency: start sampled at edge k → code_valid=1 and first code visible after edge k; done rises 16*DWELL cycles after that, for a single pass.
- start in RUN or DONE is ignored.
- abort in RUN → IDLE at the next edge:
  - code_valid=0, busy=0, no done.
  - pass_count is unchanged, even if abort coincides with the final dwell cycle; abort has priority over pass completion.
- DONE: lasts exactly one cycle with done=1, code_valid=0, busy=0; then IDLE unconditionally. abort in DONE has no effect.
- dir is latched on start acceptance; changes mid-scan are ignored.
- Wrap arithmetic is modulo 16 on code_out. pass_count is never cleared except by reset.

Optional Feature:
Macro SCAN_SKIP_MASK_EN.
- Defined:
  - Adds input port skip_mask[15:0], registered on start acceptance.
  - Codes whose mask bit is 1 are never presented: after the dwell of code c, code_out jumps to the next unmasked code in the scan direction.
  - The first code is the first unmasked code from the start end.
  - "Last code" means the last unmasked code.
  - A single unmasked code is held DWELL cycles per pass.
  - Mask all ones at start → DONE at the next edge (done pulse, code_valid never high, pass_count unchanged).
- Undefined: the port is absent and all 16 codes are scanned.

Test Plan:
- Reset with DWELL=10, pulse start, dir=0, continuous=0 → code_out 0,1,…,15, each with code_valid high for 10 cycles; done pulses once 160 cycles after the first valid; pass_count=1; then back to IDLE.
- dir=1 single pass → code_out 15 down to 0; done asserted; pass_count increments by one.
- continuous=1 for 3 passes, then continuous=0 → code_out wraps 15→0 with no gap; pass_count=3 before the final pass and 4 after; exactly one done pulse.
- abort at code 7, mid-dwell → code_valid=0 next cycle, no done, pass_count unchanged; start accepted again from code 0. Start and abort together in IDLE → remains IDLE.
- rst_n driven low asynchronously mid-RUN (between clock edges) → all outputs reset immediately without waiting for clk; also check pass_count saturation at 255 with PASS_W=8.
- SCAN_SKIP_MASK_EN, skip_mask=16'h00FF, dir=0 → only codes 8..15 presented. skip_mask=16'hFFFF → done next cycle, code_valid never high.
